// File: rtl/ray_dispatch_scheduler_if.sv
// Generator-side and tracer-side buses of the ray dispatch scheduler.
// slave: scheduler view; master: generator/tracer-array view.
interface ray_dispatch_scheduler_if #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned DATA_W    = 32
);
  logic                 gen_valid;
  logic                 gen_ready;
  logic [DATA_W-1:0]    gen_ray_x;
  logic [DATA_W-1:0]    gen_ray_y;
  logic [DATA_W-1:0]    gen_ray_z;
  logic [31:0]          gen_index;
  logic [NUM_UNITS-1:0] unit_issue;
  logic [DATA_W-1:0]    unit_ray_x;
  logic [DATA_W-1:0]    unit_ray_y;
  logic [DATA_W-1:0]    unit_ray_z;
  logic [31:0]          unit_index;
  logic [NUM_UNITS-1:0] unit_done;

  modport slave (
    input  gen_valid, gen_ray_x, gen_ray_y, gen_ray_z, gen_index, unit_done,
    output gen_ready, unit_issue, unit_ray_x, unit_ray_y, unit_ray_z, unit_index
  );

  modport master (
    output gen_valid, gen_ray_x, gen_ray_y, gen_ray_z, gen_index, unit_done,
    input  gen_ready, unit_issue, unit_ray_x, unit_ray_y, unit_ray_z, unit_index
  );
endinterface

// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler: buffers one frame of generator rays in a FIFO and
// issues them round-robin to free tracing units, tracking in-flight rays
// until every issued ray has retired.
// Optional feature: RAY_DISPATCH_STALL_STATS_EN builds the stall-cycle counter.
// Note: reset_n is active-high despite its name.
module ray_dispatch_scheduler #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [31:0]                   pixel_count,
  ray_dispatch_scheduler_if.slave       bus,
  output logic                          frame_busy,
  output logic                          frame_done,
  output logic [31:0]                   issued_count,
  output logic [31:0]                   retired_count,
  output logic                          protocol_err,
  output logic [31:0]                   stall_cycles
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned UW      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned ENTRY_W = 3 * DATA_W + 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [NUM_UNITS-1:0] r_inflight;
  logic [UW-1:0]        r_last_grant;
  logic [31:0]          r_pixel_count;
  logic [31:0]          r_accepted;
  logic [31:0]          r_issued;
  logic [31:0]          r_retired;
  logic                 r_gen_ready;
  logic [NUM_UNITS-1:0] r_unit_issue;
  logic [DATA_W-1:0]    r_ray_x;
  logic [DATA_W-1:0]    r_ray_y;
  logic [DATA_W-1:0]    r_ray_z;
  logic [31:0]          r_index;
  logic                 r_frame_busy;
  logic                 r_frame_done;
  logic                 r_protocol_err;

  logic                 w_active;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_any_free;
  logic [UW-1:0]        w_grant_idx;
  logic [NUM_UNITS-1:0] w_grant_vec;
  logic [NUM_UNITS-1:0] w_done_ok;
  logic [NUM_UNITS-1:0] w_done_bad;
  logic [31:0]          w_retire_cnt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [31:0]          w_accepted_nxt;
  logic [ENTRY_W-1:0]   w_head;

  assign w_active       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_push         = bus.gen_valid && r_gen_ready;
  assign w_pop          = w_active && (r_count != '0) && w_any_free;
  assign w_done_ok      = bus.unit_done & r_inflight;
  assign w_done_bad     = bus.unit_done & ~r_inflight;
  assign w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_accepted_nxt = r_accepted + 32'(w_push);
  assign w_head         = r_mem[r_rd_ptr];

  // Round-robin search for the first idle unit after the last grant.
  always_comb begin
    int j;
    j           = 0;
    w_any_free  = 1'b0;
    w_grant_idx = r_last_grant;
    for (int k = 1; k <= int'(NUM_UNITS); k++) begin
      j = int'(r_last_grant) + k;
      if (j >= int'(NUM_UNITS)) j = j - int'(NUM_UNITS);
      if (!w_any_free && !r_inflight[UW'(j)]) begin
        w_any_free  = 1'b1;
        w_grant_idx = UW'(j);
      end
    end
    w_grant_vec = NUM_UNITS'(w_any_free) << w_grant_idx;
  end

  // Number of valid retirements this cycle.
  always_comb begin
    w_retire_cnt = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      w_retire_cnt = w_retire_cnt + 32'(w_done_ok[UW'(i)]);
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.gen_ray_x, bus.gen_ray_y, bus.gen_ray_z, bus.gen_index};
    end
  end

  // Frame FSM, FIFO pointers, in-flight tracking and registered outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_inflight     <= '0;
      r_last_grant   <= UW'(NUM_UNITS - 1);
      r_pixel_count  <= '0;
      r_accepted     <= '0;
      r_issued       <= '0;
      r_retired      <= '0;
      r_gen_ready    <= 1'b0;
      r_unit_issue   <= '0;
      r_ray_x        <= '0;
      r_ray_y        <= '0;
      r_ray_z        <= '0;
      r_index        <= '0;
      r_frame_busy   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_gen_ready    <= 1'b0;
      r_frame_done   <= 1'b0;
      r_unit_issue   <= '0;
      r_count        <= w_count_nxt;
      r_retired      <= r_retired + w_retire_cnt;
      r_protocol_err <= r_protocol_err | (|w_done_bad);
      r_inflight     <= (r_inflight & ~w_done_ok) | (w_pop ? w_grant_vec : '0);

      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_accepted <= w_accepted_nxt;
      end

      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
        r_last_grant <= w_grant_idx;
        r_issued     <= r_issued + 32'd1;
        r_unit_issue <= w_grant_vec;
        r_ray_x      <= w_head[ENTRY_W-1 -: DATA_W];
        r_ray_y      <= w_head[2*DATA_W+31 -: DATA_W];
        r_ray_z      <= w_head[DATA_W+31 -: DATA_W];
        r_index      <= w_head[31:0];
      end

      // Frame sequencing; counter clears here override the datapath updates.
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pixel_count <= pixel_count;
            r_accepted    <= '0;
            r_issued      <= '0;
            r_retired     <= '0;
            r_frame_busy  <= 1'b1;
            if (pixel_count != 32'd0) begin
              r_state     <= ST_RUN;
              r_gen_ready <= 1'b1;
            end else begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_gen_ready <= (w_count_nxt < CNT_W'(FIFO_DEPTH)) &&
                         (w_accepted_nxt < r_pixel_count);
          if (r_accepted == r_pixel_count) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((r_retired == r_pixel_count) && (r_count == '0)) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_frame_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAY_DISPATCH_STALL_STATS_EN
  logic        w_stall;
  logic [31:0] r_stall_cycles;

  assign w_stall = w_active && (r_count != '0) && !w_any_free;

  // Saturating count of cycles with rays waiting but every unit busy.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

  assign bus.gen_ready  = r_gen_ready;
  assign bus.unit_issue = r_unit_issue;
  assign bus.unit_ray_x = r_ray_x;
  assign bus.unit_ray_y = r_ray_y;
  assign bus.unit_ray_z = r_ray_z;
  assign bus.unit_index = r_index;

  assign frame_busy    = r_frame_busy;
  assign frame_done    = r_frame_done;
  assign issued_count  = r_issued;
  assign retired_count = r_retired;
  assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Directed bench for ray_dispatch_scheduler: a 4-unit and a 1-unit instance,
// each with a free-running generator and a fixed-latency tracer responder.
module tb_ray_dispatch_scheduler;

  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] pc4 = '0;
  logic [31:0] pc1 = '0;

  logic        busy4, done4, perr4, busy1, done1, perr1;
  logic [31:0] issued4, retired4, stall4, issued1, retired1, stall1;

  logic [3:0]  resp_done4 = '0;
  logic [3:0]  inj_done4  = '0;
  logic [0:0]  resp_done1 = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ray_dispatch_scheduler_if #(.NUM_UNITS(4), .DATA_W(DW)) if4 ();
  ray_dispatch_scheduler_if #(.NUM_UNITS(1), .DATA_W(DW)) if1 ();

  assign if4.unit_done = resp_done4 | inj_done4;
  assign if1.unit_done = resp_done1;

  ray_dispatch_scheduler #(.NUM_UNITS(4), .FIFO_DEPTH(4), .DATA_W(DW)) u_dut4 (
    .clk(clk), .reset_n(rst), .start(start4), .pixel_count(pc4), .bus(if4),
    .frame_busy(busy4), .frame_done(done4), .issued_count(issued4),
    .retired_count(retired4), .protocol_err(perr4), .stall_cycles(stall4)
  );

  ray_dispatch_scheduler #(.NUM_UNITS(1), .FIFO_DEPTH(4), .DATA_W(DW)) u_dut1 (
    .clk(clk), .reset_n(rst), .start(start1), .pixel_count(pc1), .bus(if1),
    .frame_busy(busy1), .frame_done(done1), .issued_count(issued1),
    .retired_count(retired1), .protocol_err(perr1), .stall_cycles(stall1)
  );

  function automatic logic [31:0] fx(input int i); return 32'(i * 3 + 1);          endfunction
  function automatic logic [31:0] fy(input int i); return 32'(i + 100);            endfunction
  function automatic logic [31:0] fz(input int i); return 32'(i) ^ 32'h5A5A_5A5A;  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observed issues and frame_done pulses.
  int          q4_grant[$];
  int          q4_idx[$];
  logic [31:0] q4_x[$];
  int          q1_idx[$];
  int          fd4 = 0;
  int          fd1 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (if4.unit_issue != '0) begin
        q4_grant.push_back(int'(if4.unit_issue));
        q4_idx.push_back(int'(if4.unit_index));
        q4_x.push_back(if4.unit_ray_x);
      end
      if (if1.unit_issue != '0) q1_idx.push_back(int'(if1.unit_index));
      if (done4) fd4++;
      if (done1) fd1++;
    end
  end

  // Tracer responders: retire a unit lat cycles after its issue (lat 0 = never).
  int lat4 = 1;
  int lat1 = 4;
  int tmr4[4];
  int tmr1 = 0;

  initial begin
    for (int i = 0; i < 4; i++) tmr4[2'(i)] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        resp_done4[2'(i)] = 1'b0;
        if (tmr4[2'(i)] > 0) begin
          tmr4[2'(i)]--;
          if (tmr4[2'(i)] == 0) resp_done4[2'(i)] = 1'b1;
        end
        if (if4.unit_issue[2'(i)] && lat4 > 0) tmr4[2'(i)] = lat4;
      end
      resp_done1 = 1'b0;
      if (tmr1 > 0) begin
        tmr1--;
        if (tmr1 == 0) resp_done1 = 1'b1;
      end
      if (if1.unit_issue[0] && lat1 > 0) tmr1 = lat1;
    end
  end

  // Generators: always valid, ray k carries index k; restartable from 0.
  logic g4_restart = 1'b0;
  int   g4_idx = 0;
  bit   g4_pend = 1'b0;
  int   g1_idx = 0;
  bit   g1_pend = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (g4_restart) begin
        g4_idx     = 0;
        g4_pend    = 1'b0;
        g4_restart = 1'b0;
      end else if (g4_pend) begin
        g4_idx++;
      end
      if (g1_pend) g1_idx++;
      if4.gen_valid = 1'b1;
      if4.gen_ray_x = fx(g4_idx);
      if4.gen_ray_y = fy(g4_idx);
      if4.gen_ray_z = fz(g4_idx);
      if4.gen_index = 32'(g4_idx);
      g4_pend       = if4.gen_ready;
      if1.gen_valid = 1'b1;
      if1.gen_ray_x = fx(g1_idx);
      if1.gen_ray_y = fy(g1_idx);
      if1.gen_ray_z = fz(g1_idx);
      if1.gen_index = 32'(g1_idx);
      g1_pend       = if1.gen_ready;
    end
  end

  task automatic wait_done(input string tag, input bit which1, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (which1 ? done1 : done4) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  int          base;
  int          fd_before;
  logic [31:0] s1;

  initial begin
    if4.gen_valid = 1'b0;
    if1.gen_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gen_ready", 32'(if4.gen_ready), 32'd0);
    chk("rst_issue",     32'(if4.unit_issue), 32'd0);
    chk("rst_busy",      32'(busy4), 32'd0);
    chk("rst_done",      32'(done4), 32'd0);
    chk("rst_perr",      32'(perr4), 32'd0);
    chk("rst_issued",    issued4, 32'd0);
    chk("rst_retired",   retired4, 32'd0);
    chk("rst_stall",     stall4, 32'd0);
    chk("rst_ray_x",     if4.unit_ray_x, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single unit, 3-ray frame.
    start1 = 1'b1; pc1 = 32'd3;
    @(negedge clk);
    start1 = 1'b0;
    chk("one_busy", 32'(busy1), 32'd1);
    wait_done("one_frame_done", 1'b1, 200);
    chk("one_issued",  issued1, 32'd3);
    chk("one_retired", retired1, 32'd3);
    chk("one_nissue",  32'(q1_idx.size()), 32'd3);
    if (q1_idx.size() == 3) chk("one_last_idx", 32'(q1_idx[2]), 32'd2);
    repeat (3) @(negedge clk);
    chk("one_done_pulses", 32'(fd1), 32'd1);
    chk("one_busy_end",    32'(busy1), 32'd0);
    chk("one_perr",        32'(perr1), 32'd0);

    // Round robin, 4 units, 8 rays, retire 1 cycle after issue.
    start4 = 1'b1; pc4 = 32'd8;
    @(negedge clk);
    start4 = 1'b0;
    wait_done("rr_frame_done", 1'b0, 200);
    chk("rr_issued",  issued4, 32'd8);
    chk("rr_retired", retired4, 32'd8);
    chk("rr_nissue",  32'(q4_grant.size()), 32'd8);
    if (q4_grant.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rr_grant%0d", k), 32'(q4_grant[k]), 32'd1 << (k % 4));
        chk($sformatf("rr_index%0d", k), 32'(q4_idx[k]), 32'(k));
      end
      chk("rr_ray_x5", q4_x[5], 32'd16);
    end
    chk("rr_perr", 32'(perr4), 32'd0);
    repeat (2) @(negedge clk);

    // Zero-length frame: DONE straight after the accepted start.
    base = q4_grant.size();
    start4 = 1'b1; pc4 = 32'd0;
    @(negedge clk);
    start4 = 1'b0;
    chk("zero_done",   32'(done4), 32'd1);
    chk("zero_busy",   32'(busy4), 32'd1);
    chk("zero_issued", issued4, 32'd0);
    @(negedge clk);
    chk("zero_done_end", 32'(done4), 32'd0);
    chk("zero_busy_end", 32'(busy4), 32'd0);
    chk("zero_noissue",  32'(q4_grant.size() - base), 32'd0);

    // Second start during RUN must be ignored.
    g4_restart = 1'b1; lat4 = 3;
    repeat (2) @(negedge clk);
    base = q4_grant.size();
    start4 = 1'b1; pc4 = 32'd2;
    @(negedge clk);
    pc4 = 32'd5;
    @(negedge clk);
    start4 = 1'b0;
    wait_done("ign_frame_done", 1'b0, 200);
    chk("ign_issued",  issued4, 32'd2);
    chk("ign_retired", retired4, 32'd2);
    chk("ign_nissue",  32'(q4_grant.size() - base), 32'd2);
    repeat (3) @(negedge clk);
    chk("ign_busy_end", 32'(busy4), 32'd0);

    // Retire on an idle unit: sticky error, no count.
    inj_done4 = 4'b0100;
    @(negedge clk);
    inj_done4 = 4'b0000;
    chk("perr_set",     32'(perr4), 32'd1);
    chk("perr_retired", retired4, 32'd2);

    // FIFO full: units never retire, 20-ray frame.
    g4_restart = 1'b1; lat4 = 0;
    repeat (2) @(negedge clk);
    base = q4_grant.size();
    start4 = 1'b1; pc4 = 32'd20;
    @(negedge clk);
    start4 = 1'b0;
    repeat (20) @(negedge clk);
    chk("full_issued",    issued4, 32'd4);
    chk("full_nissue",    32'(q4_grant.size() - base), 32'd4);
    if (q4_grant.size() - base == 4) begin
      chk("full_grant0", 32'(q4_grant[base]),     32'd4);
      chk("full_grant1", 32'(q4_grant[base + 1]), 32'd8);
      chk("full_grant2", 32'(q4_grant[base + 2]), 32'd1);
      chk("full_grant3", 32'(q4_grant[base + 3]), 32'd2);
    end
    chk("full_gen_ready", 32'(if4.gen_ready), 32'd0);
    chk("full_accepted",  32'(g4_idx), 32'd8);
    chk("full_busy",      32'(busy4), 32'd1);
    chk("full_perr_sticky", 32'(perr4), 32'd1);
    s1 = stall4;
    @(negedge clk);
`ifdef RAY_DISPATCH_STALL_STATS_EN
    chk("full_stall_inc", stall4, s1 + 32'd1);
`else
    chk("full_stall_zero", stall4, 32'd0);
`endif

    // Reset mid-frame: immediate return to reset values, no frame_done.
    fd_before = fd4;
    rst = 1'b1;
    #1;
    chk("mrst_busy",      32'(busy4), 32'd0);
    chk("mrst_gen_ready", 32'(if4.gen_ready), 32'd0);
    chk("mrst_perr",      32'(perr4), 32'd0);
    chk("mrst_issued",    issued4, 32'd0);
    chk("mrst_stall",     stall4, 32'd0);
    chk("mrst_index",     if4.unit_index, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_no_done",  32'(fd4 - fd_before), 32'd0);
    chk("mrst_idle",     32'(busy4), 32'd0);
    chk("mrst_issue",    32'(if4.unit_issue), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
